// File: rtl/mem_arbiter_burst.sv
// mem_arbiter_burst: arbitrates icache/dcache line requests onto one
// 64-bit burst memory port. Each line moves as a BEATS-beat burst, and read
// beats are reassembled into a full line.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: when both caches request in
// the same IDLE cycle, the cache that did not own the previous transaction
// wins. Without it, dcache always has priority over icache.
module mem_arbiter_burst #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 64,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);

  if (LINE_W != BEATS * BEAT_W) begin : g_bad_cfg
    $error("LINE_W must equal BEATS*BEAT_W");
  end

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [BEATS-1:0][BEAT_W-1:0]  buf_q, buf_d;
  logic [31:0]                   addr_q, addr_d;
  logic                          rd_q, rd_d, wr_q, wr_d;
  logic                          i_resp_q, i_resp_d, d_resp_q, d_resp_d;
  logic [LINE_W-1:0]             i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                          d_req, grant_d, last_beat;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = dcache owned the previous transaction
  logic                          last_d_q, last_d_d;
`endif

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign d_req     = d_read | d_write;

  // Next-state, beat counting, line assembly and response generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    addr_d    = addr_q;
    i_resp_d  = 1'b0;
    d_resp_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_d   = d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d_d  = last_d_q;
    // On a cross-cache collision the previous non-owner wins
    if (d_req && i_read) grant_d = ~last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          addr_d = {d_addr[31:OFF_W], OFF_W'(0)};
          // A write always beats a read from the same cache
          if (d_write) begin
            state_d = D_WR;
            buf_d   = d_wdata;
          end else begin
            state_d = D_RD;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`endif
        end else if (i_read) begin
          addr_d  = {i_addr[31:OFF_W], OFF_W'(0)};
          state_d = I_RD;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d_d = 1'b0;
`endif
        end
      end
      I_RD, D_RD: begin
        if (mem_resp) begin
          buf_d[cnt_q] = mem_rdata;
          cnt_d        = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = DONE;
            // Publish the line together with the response pulse
            if (state_q == I_RD) begin
              i_resp_d  = 1'b1;
              i_rdata_d = buf_d;
            end else begin
              d_resp_d  = 1'b1;
              d_rdata_d = buf_d;
            end
          end
        end
      end
      D_WR: begin
        if (mem_resp) begin
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d  = DONE;
            d_resp_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_d = (state_d == I_RD) || (state_d == D_RD);
    wr_d = (state_d == D_WR);
  end

  // Registered FSM state and outputs; reset aborts any burst immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      buf_q     <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  // Write beat follows the counter directly so a stalled beat stays on the bus
  assign mem_wdata = wr_q ? buf_q[cnt_q] : '0;
  assign i_resp    = i_resp_q;
  assign d_resp    = d_resp_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter_burst.sv
// Directed bench for mem_arbiter_burst: cycle table for a read and a gapped
// write, then hand sequences for reset abort, address hold, collisions.
module tb_mem_arbiter_burst;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, d_read, d_write, mem_resp;
  logic [31:0]  i_addr, d_addr, mem_addr;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic         i_resp, d_resp, mem_read, mem_write;
  logic [63:0]  mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_arbiter_burst dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr, dw;
    logic [31:0] da;
    logic        mr;
    logic [63:0] md;
    logic        e_rd, e_wr, e_ir, e_dr;
    logic [31:0] e_addr;
    logic [63:0] e_wd;
  } vec_t;

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] A0 = 64'hA0A0_A0A0_A0A0_A0A0;
  localparam logic [63:0] A1 = 64'hA1A1_A1A1_A1A1_A1A1;
  localparam logic [63:0] A2 = 64'hA2A2_A2A2_A2A2_A2A2;
  localparam logic [63:0] A3 = 64'hA3A3_A3A3_A3A3_A3A3;
  localparam logic [31:0] DA = 32'h8000_0020;

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic mr, logic [63:0] md,
                              logic e_rd, logic e_wr, logic e_ir, logic e_dr,
                              logic [31:0] e_addr, logic [63:0] e_wd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.mr = mr; v.md = md;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_ir = e_ir; v.e_dr = e_dr;
    v.e_addr = e_addr; v.e_wd = e_wd;
    return v;
  endfunction

  function automatic logic [63:0] beatv(int b, logic [7:0] s);
    logic [7:0] x;
    x = 8'((b + 1) * 17) ^ s;
    return {8{x}};
  endfunction

  function automatic logic [255:0] linev(logic [7:0] s);
    return {beatv(3, s), beatv(2, s), beatv(1, s), beatv(0, s)};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Wait (bounded) until a burst is on the bus; returns at negedge+1
  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (mem_read || mem_write) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Serve one burst with back-to-back beats; report owner at DONE (1=d, 0=i)
  task automatic serve_burst(input logic [7:0] salt, output int owner, output int when);
    bit ok;
    owner = -1;
    when  = cyc;
    wait_busy(ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout got=none want=burst");
      return;
    end
    for (int b = 0; b < 4; b++) begin
      mem_resp  = 1'b1;
      mem_rdata = beatv(b, salt);
      @(negedge clk); #1;
    end
    mem_resp  = 1'b0;
    mem_rdata = '0;
    owner = d_resp ? 1 : (i_resp ? 0 : -1);
    when  = cyc;
  endtask

  vec_t vt[16];
  int   o1, o2, t1, t2;
  int   exp_own[3];
  bit   ok;

  initial begin
    vt[0]  = mk(1, 32'h64, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0,     0);
    vt[1]  = mk(1, 32'h64, 0, 0, 0,  1, B1, 1, 0, 0, 0, 32'h60, 0);
    vt[2]  = mk(1, 32'h64, 0, 0, 0,  1, B2, 1, 0, 0, 0, 32'h60, 0);
    vt[3]  = mk(1, 32'h64, 0, 0, 0,  1, B3, 1, 0, 0, 0, 32'h60, 0);
    vt[4]  = mk(1, 32'h64, 0, 0, 0,  1, B4, 1, 0, 0, 0, 32'h60, 0);
    vt[5]  = mk(0, 0,      0, 0, 0,  0, 0,  0, 0, 1, 0, 0,     0);
    vt[6]  = mk(0, 0,      0, 0, 0,  0, 0,  0, 0, 0, 0, 0,     0);
    // d_read held with d_write (illegal combination): the write must win
    vt[7]  = mk(0, 0,      1, 1, DA, 0, 0,  0, 0, 0, 0, 0,     0);
    vt[8]  = mk(0, 0,      1, 1, DA, 1, 0,  0, 1, 0, 0, DA,    A0);
    vt[9]  = mk(0, 0,      1, 1, DA, 0, 0,  0, 1, 0, 0, DA,    A1);
    vt[10] = mk(0, 0,      1, 1, DA, 0, 0,  0, 1, 0, 0, DA,    A1);
    vt[11] = mk(0, 0,      1, 1, DA, 1, 0,  0, 1, 0, 0, DA,    A1);
    vt[12] = mk(0, 0,      1, 1, DA, 1, 0,  0, 1, 0, 0, DA,    A2);
    vt[13] = mk(0, 0,      1, 1, DA, 1, 0,  0, 1, 0, 0, DA,    A3);
    vt[14] = mk(0, 0,      0, 0, 0,  0, 0,  0, 0, 0, 1, 0,     0);
    vt[15] = mk(0, 0,      0, 0, 0,  0, 0,  0, 0, 0, 0, 0,     0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_own = '{1, 0, 1};
`else
    exp_own = '{1, 1, 1};
`endif

    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_addr = 0; d_addr = 0; mem_rdata = 0;
    d_wdata = {A3, A2, A1, A0};
    @(negedge clk); @(negedge clk); #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp", {i_resp, d_resp}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;

    // Cycle table: icache read then gapped dcache write
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      i_read = vt[k].ir; i_addr = vt[k].ia; d_read = vt[k].dr; d_write = vt[k].dw;
      d_addr = vt[k].da; mem_resp = vt[k].mr; mem_rdata = vt[k].md;
      #1;
      chk($sformatf("v%0d_mem_read", k), mem_read, vt[k].e_rd);
      chk($sformatf("v%0d_mem_write", k), mem_write, vt[k].e_wr);
      chk($sformatf("v%0d_i_resp", k), i_resp, vt[k].e_ir);
      chk($sformatf("v%0d_d_resp", k), d_resp, vt[k].e_dr);
      if (vt[k].e_rd || vt[k].e_wr) chk($sformatf("v%0d_mem_addr", k), mem_addr, vt[k].e_addr);
      if (vt[k].e_wr) chk($sformatf("v%0d_mem_wdata", k), mem_wdata, vt[k].e_wd);
    end
    chk("table_i_rdata", i_rdata, {B4, B3, B2, B1});
    chk("table_d_rdata_untouched", d_rdata, 0);

    // Reset after two beats of a read aborts it; the retry starts at beat 0
    @(negedge clk); i_read = 1; i_addr = 32'h1240;
    wait_busy(ok);
    chk("rstmid_started", ok, 1);
    for (int b = 0; b < 2; b++) begin
      mem_resp = 1; mem_rdata = beatv(b, 8'hEE);
      @(negedge clk); #1;
    end
    mem_resp = 0;
    #1 rst = 1'b1;
    #1;
    chk("rstmid_mem_read_async", mem_read, 0);
    chk("rstmid_i_resp", i_resp, 0);
    chk("rstmid_i_rdata_cleared", i_rdata, 0);
    rst = 1'b0;
    serve_burst(8'h5A, o1, t1);
    chk("rstmid_retry_owner", o1, 0);
    chk("rstmid_retry_line", i_rdata, linev(8'h5A));
    i_read = 0;

    // Address change mid-burst is ignored
    @(negedge clk); i_read = 1; i_addr = 32'h100;
    wait_busy(ok);
    chk("addr_started", ok, 1);
    chk("addr_latched", mem_addr, 32'h100);
    i_addr = 32'h200;
    for (int b = 0; b < 4; b++) begin
      mem_resp = 1; mem_rdata = beatv(b, 8'h07);
      @(negedge clk); #1;
      chk($sformatf("addr_hold_%0d", b), mem_addr, 32'h100);
    end
    mem_resp = 0;
    chk("addr_i_resp", i_resp, 1);
    i_read = 0;

    // Simultaneous icache/dcache reads: dcache first, icache 6 cycles later
    @(negedge clk); i_read = 1; d_read = 1; i_addr = 32'h300; d_addr = 32'h400;
    serve_burst(8'h3C, o1, t1);
    chk("coll_first_owner", o1, 1);
    chk("coll_d_line", d_rdata, linev(8'h3C));
    d_read = 0;
    serve_burst(8'hC3, o2, t2);
    chk("coll_second_owner", o2, 0);
    chk("coll_resp_gap", t2 - t1, 6);
    chk("coll_i_line", i_rdata, linev(8'hC3));
    i_read = 0;

    // Both caches hold requests across three grants
    @(negedge clk); i_read = 1; d_read = 1;
    for (int r = 0; r < 3; r++) begin
      serve_burst(8'(r * 8 + 1), o1, t1);
      chk($sformatf("held_owner_%0d", r), o1, exp_own[r]);
    end
    i_read = 0; d_read = 0;
    @(negedge clk); @(negedge clk); #1;
    chk("final_idle", {mem_read, mem_write}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
